hl_reset_sequencer: RTL and testbench
=====================================

HL_RESET_SEQUENCER -- requirements
Module: hl_reset_sequencer

Interface
REQ-001 SHALL have parameter NDOM, default 4: number of sequenced reset domains (1..16).
REQ-002 SHALL have parameter NLOCK, default 2: number of PLL lock inputs (1..8).
REQ-003 SHALL have parameter LOCK_FILTER, default 16: consecutive all-locked cycles required before lock is considered stable (>=1).
REQ-004 SHALL have parameter HOLD_CYCLES, default 1024: cycles all resets stay asserted after stable lock (>=1).
REQ-005 SHALL have parameter STAGGER, default 256: cycles between successive domain releases (>=1).
REQ-006 SHALL have port rstclk, input, 1: the single clock, the same slow clock that drives reset and EEPROM logic.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port locked_i, input, NLOCK: PLL lock flags, already synchronous to rstclk.
REQ-009 SHALL have port swrst_i, input, 1: software reset request, single-cycle pulse.
REQ-010 SHALL have port rst_o, output, NDOM: per-domain active-high resets; bit 0 is released first.
REQ-011 SHALL have port running_o, output, 1: high only in state RUN.
REQ-012 SHALL have port fault_cnt_o, output, 8: saturating lock-loss counter.
REQ-013 SHALL have port state_o, output, 3: encoded current state, for the LEDs and debug.

Function
REQ-014 States SHALL be RESET, WAIT_LOCK, HOLD, RELEASE and RUN.
REQ-015 RESET: rst_o is all ones; the next state is unconditionally WAIT_LOCK once rst is low.
REQ-016 WAIT_LOCK: the filter counter increments while &locked_i and clears on any low bit; on the cycle the count reaches LOCK_FILTER the state becomes HOLD.
REQ-017 HOLD: the counter counts HOLD_CYCLES cycles with rst_o all ones, then the state becomes RELEASE with index k=0.
REQ-018 RELEASE: rst_o[0] SHALL deassert on the first RELEASE cycle.
REQ-019 RELEASE: rst_o[k] SHALL deassert exactly k*STAGGER cycles after rst_o[0] deasserts.
REQ-020 RELEASE: the state becomes RUN on the cycle after rst_o[NDOM-1] deasserts; with NDOM=1 it becomes RUN immediately after the first RELEASE cycle.
REQ-021 Once a bit of rst_o is released it SHALL stay low until a reassert event.
REQ-022 Lock loss: in HOLD, RELEASE or RUN, any locked_i bit low (raw, unfiltered) SHALL, on the next cycle, set rst_o all ones, enter WAIT_LOCK, clear counters and increment fault_cnt_o.
REQ-023 fault_cnt_o SHALL saturate at 255.
REQ-024 Software reset: swrst_i high in RELEASE or RUN SHALL, on the next cycle, set rst_o all ones and enter HOLD with the counter cleared; fault_cnt_o is unchanged.
REQ-025 swrst_i SHALL be ignored in RESET, WAIT_LOCK and HOLD.
REQ-026 When lock loss and swrst_i occur in the same cycle, lock loss SHALL win.
REQ-027 rst_o, running_o and state_o SHALL be registered outputs with no combinational path from any input.
REQ-028 Counter width SHALL be ceil(log2(max(LOCK_FILTER, HOLD_CYCLES, STAGGER)+1)) bits; the counter never wraps.

Reset
REQ-029 rst high SHALL, on the next rstclk edge, force: state RESET, rst_o all ones, running_o 0, fault_cnt_o 0, all counters 0.
REQ-030 rst SHALL override every other input in every state, including mid-RELEASE.
REQ-031 No asynchronous reset SHALL be used anywhere in the block.

Structure
REQ-032 The state encoding and the counter-width function SHALL live in the shared package hl_pkg.
REQ-033 Lock filtering SHALL be a sub-module hl_lock_filter (parameter LOCK_FILTER; inputs rstclk, rst, clear, lock_all; output stable).
REQ-034 All logic SHALL be in the rstclk domain.

Verification (NDOM=3, NLOCK=2, LOCK_FILTER=4, HOLD_CYCLES=8, STAGGER=4)
REQ-035 Release sequence: rst low, locked_i=2'b11 from cycle 0 -> HOLD entered at cycle 4; rst_o[0] falls at cycle 12, rst_o[1] at cycle 16, rst_o[2] at cycle 20; running_o=1 at cycle 21.
REQ-036 Lock glitch: locked_i=2'b01 for 1 cycle on cycle 2 of WAIT_LOCK -> filter restarts; HOLD is entered 4 cycles after locked_i returns to 2'b11.
REQ-037 Lock loss in RUN: locked_i[1]=0 for 1 cycle -> rst_o=3'b111 next cycle, state WAIT_LOCK, fault_cnt_o=1; 256 such losses -> fault_cnt_o=255.
REQ-038 swrst_i pulse in RUN -> rst_o=3'b111 next cycle, 8 HOLD cycles, staggered release repeats, fault_cnt_o unchanged; swrst_i and a lock drop in the same cycle -> WAIT_LOCK and fault_cnt_o incremented.
REQ-039 rst asserted between the rst_o[0] and rst_o[1] releases -> next cycle rst_o=3'b111, fault_cnt_o=0, state RESET.
REQ-040 swrst_i pulsed during HOLD -> no effect; release timing is identical to REQ-035.

Source files
------------

// File: rtl/hl_pkg.sv
// Shared types and sizing helpers for the reset sequencer slice.
// State codes double as the LED/debug encoding on state_o.
package hl_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } hl_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int cnt_width(input int maxv);
        return (maxv < 1) ? 1 : $clog2(maxv + 1);
    endfunction

endpackage

// File: rtl/hl_lock_filter.sv
// Debounces the combined PLL lock flag: stable only after
// LOCK_FILTER consecutive locked cycles.
module hl_lock_filter
    import hl_pkg::*;
#(
    parameter int LOCK_FILTER = 16
) (
    input  logic rstclk,
    input  logic rst,
    input  logic clear,
    input  logic lock_all,
    output logic stable
);

    localparam int W = cnt_width(LOCK_FILTER);
    localparam logic [W-1:0] LIMIT = W'(LOCK_FILTER);
    localparam logic [W-1:0] LAST  = W'(LOCK_FILTER - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge rstclk) begin
        if (rst || clear || !lock_all) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Asserted on the edge where the count reaches LOCK_FILTER.
    assign stable = lock_all && !clear && (cnt >= LAST);

endmodule

// File: rtl/hl_reset_sequencer.sv
// Board reset sequencer: waits for stable PLL lock, holds all resets,
// then releases domains one by one, STAGGER cycles apart.
module hl_reset_sequencer
    import hl_pkg::*;
#(
    parameter int NDOM        = 4,
    parameter int NLOCK       = 2,
    parameter int LOCK_FILTER = 16,
    parameter int HOLD_CYCLES = 1024,
    parameter int STAGGER     = 256
) (
    input  logic             rstclk,
    input  logic             rst,
    input  logic [NLOCK-1:0] locked_i,
    input  logic             swrst_i,
    output logic [NDOM-1:0]  rst_o,
    output logic             running_o,
    output logic [7:0]       fault_cnt_o,
    output logic [2:0]       state_o
);

    localparam int CW =
        cnt_width(max3(LOCK_FILTER, HOLD_CYCLES, STAGGER));
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER - 1);

    hl_state_t     state;
    logic [CW-1:0] cnt;
    logic          lock_all;
    logic          stable;
    logic          live;
    logic          sw_ok;

    assign lock_all = &locked_i;
    assign state_o  = state;

    always_comb begin
        live  = 1'b0;
        sw_ok = 1'b0;
        unique case (1'b1)
            (state == ST_HOLD): live = 1'b1;
            (state == ST_RELEASE),
            (state == ST_RUN): begin
                live  = 1'b1;
                sw_ok = 1'b1;
            end
            default: ;
        endcase
    end

    hl_lock_filter #(
        .LOCK_FILTER(LOCK_FILTER)
    ) u_filter (
        .rstclk  (rstclk),
        .rst     (rst),
        .clear   (live),
        .lock_all(lock_all),
        .stable  (stable)
    );

    // Priority: rst, then raw lock loss, then software reset.
    always_ff @(posedge rstclk) begin
        if (rst) begin
            state       <= ST_RESET;
            rst_o       <= '1;
            running_o   <= 1'b0;
            fault_cnt_o <= 8'd0;
            cnt         <= '0;
        end else if (live && !lock_all) begin
            state     <= ST_WAIT_LOCK;
            rst_o     <= '1;
            running_o <= 1'b0;
            cnt       <= '0;
            if (fault_cnt_o != 8'hff) begin
                fault_cnt_o <= fault_cnt_o + 8'd1;
            end
        end else if (sw_ok && swrst_i) begin
            state     <= ST_HOLD;
            rst_o     <= '1;
            running_o <= 1'b0;
            cnt       <= '0;
        end else begin
            unique case (state)
                ST_RESET: begin
                    state     <= ST_WAIT_LOCK;
                    rst_o     <= '1;
                    running_o <= 1'b0;
                    cnt       <= '0;
                end
                ST_WAIT_LOCK: begin
                    if (stable) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                    end
                end
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= ST_RELEASE;
                        rst_o <= rst_o << 1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // rst_o shifts in zeros from bit 0, so the MSB clearing
                // marks the last domain released.
                ST_RELEASE: begin
                    if (!rst_o[NDOM-1]) begin
                        state     <= ST_RUN;
                        running_o <= 1'b1;
                    end else if (cnt == STAG_LAST) begin
                        rst_o <= rst_o << 1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: running_o <= 1'b1;
                default: begin
                    state     <= ST_RESET;
                    rst_o     <= '1;
                    running_o <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hl_reset_sequencer.sv
// Bench for hl_reset_sequencer: timeline model plus directed
// literal checks and randomized lock/swrst/rst stimulus.
module tb_hl_reset_sequencer;

    localparam int NDOM = 3;
    localparam int NLOCK = 2;
    localparam int LF = 4;
    localparam int HOLD = 8;
    localparam int ST = 4;
    localparam int T_RUN = HOLD + (NDOM - 1) * ST + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NLOCK-1:0] locked = '0;
    logic             swrst = 1'b0;
    logic [NDOM-1:0]  rst_o;
    logic             running;
    logic [7:0]       fault;
    logic [2:0]       state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hl_reset_sequencer #(
        .NDOM(NDOM),
        .NLOCK(NLOCK),
        .LOCK_FILTER(LF),
        .HOLD_CYCLES(HOLD),
        .STAGGER(ST)
    ) dut (
        .rstclk     (clk),
        .rst        (rst),
        .locked_i   (locked),
        .swrst_i    (swrst),
        .rst_o      (rst_o),
        .running_o  (running),
        .fault_cnt_o(fault),
        .state_o    (state)
    );

    // Model: mode 0 reset, 1 waiting, 2 active; in the active mode
    // everything follows from t, cycles since the hold began.
    int m_mode = 0;
    int m_run = 0;
    int m_t = 0;
    int m_fault = 0;
    bit m_ok = 1'b0;

    function automatic int exp_state();
        if (m_mode == 0) return 0;
        if (m_mode == 1) return 1;
        if (m_t < HOLD) return 2;
        if (m_t < T_RUN) return 3;
        return 4;
    endfunction

    function automatic logic [NDOM-1:0] exp_rst();
        logic [NDOM-1:0] r;
        r = '1;
        if (m_mode == 2) begin
            for (int i = 0; i < NDOM; i++) begin
                r[i] = !(m_t >= HOLD + i * ST);
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        bit lk;
        int ph;
        lk = &locked;
        ph = exp_state();
        if (rst) begin
            m_mode = 0;
            m_run = 0;
            m_t = 0;
            m_fault = 0;
            m_ok = 1'b1;
        end else if (m_ok) begin
            if (m_mode == 0) begin
                m_mode = 1;
                m_run = lk ? m_run + 1 : 0;
            end else if (m_mode == 1) begin
                m_run = lk ? m_run + 1 : 0;
                if (m_run >= LF) begin
                    m_mode = 2;
                    m_t = 0;
                    m_run = 0;
                end
            end else if (!lk) begin
                m_mode = 1;
                m_run = 0;
                if (m_fault < 255) m_fault++;
            end else if (swrst && ph >= 3) begin
                m_t = 0;
            end else if (m_t < 100000) begin
                m_t++;
            end
        end
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_state", 32'(state), 32'(exp_state()));
            chk("m_rst_o", 32'(rst_o), 32'(exp_rst()));
            chk("m_running", 32'(running),
                32'(exp_state() == 4));
            chk("m_fault", 32'(fault), 32'(m_fault));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_state(input int s, input int budget);
        int n;
        n = 0;
        while (state !== 3'(s) && n < budget) begin
            tick();
            n++;
        end
        chk("wait_state", 32'(state), 32'(s));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        swrst = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        locked = 2'b11;
    endtask

    task automatic timeline(input int sw_at);
        do_reset();
        for (int c = 1; c <= 22; c++) begin
            swrst = (c - 1 == sw_at);
            tick();
            swrst = 1'b0;
            if (c == 3) chk("tl_wait3", 32'(state), 1);
            if (c == 4) chk("tl_hold4", 32'(state), 2);
            if (c == 11) chk("tl_rst11", 32'(rst_o), 7);
            if (c == 12) chk("tl_rst12", 32'(rst_o), 6);
            if (c == 12) chk("tl_rel12", 32'(state), 3);
            if (c == 15) chk("tl_rst15", 32'(rst_o), 6);
            if (c == 16) chk("tl_rst16", 32'(rst_o), 4);
            if (c == 19) chk("tl_rst19", 32'(rst_o), 4);
            if (c == 20) chk("tl_rst20", 32'(rst_o), 0);
            if (c == 20) chk("tl_run20", 32'(running), 0);
            if (c == 21) chk("tl_run21", 32'(running), 1);
            if (c == 21) chk("tl_st21", 32'(state), 4);
        end
    endtask

    initial begin
        int dropr;
        tick();
        tick();
        chk("rst_rst_o", 32'(rst_o), 7);
        chk("rst_running", 32'(running), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_state", 32'(state), 0);

        timeline(-1);

        locked = 2'b01;
        tick();
        locked = 2'b11;
        chk("loss_rst_o", 32'(rst_o), 7);
        chk("loss_state", 32'(state), 1);
        chk("loss_fault", 32'(fault), 1);

        wait_state(4, 60);
        swrst = 1'b1;
        tick();
        swrst = 1'b0;
        chk("sw_rst_o", 32'(rst_o), 7);
        chk("sw_state", 32'(state), 2);
        chk("sw_fault", 32'(fault), 1);
        for (int i = 0; i < 7; i++) tick();
        chk("sw_hold7", 32'(state), 2);
        tick();
        chk("sw_rel_rst", 32'(rst_o), 6);
        chk("sw_rel_st", 32'(state), 3);

        wait_state(4, 60);
        swrst = 1'b1;
        locked = 2'b10;
        tick();
        swrst = 1'b0;
        locked = 2'b11;
        chk("both_state", 32'(state), 1);
        chk("both_fault", 32'(fault), 2);

        wait_state(3, 60);
        tick();
        chk("mid_rst_o", 32'(rst_o), 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_o2", 32'(rst_o), 7);
        chk("mid_fault", 32'(fault), 0);
        chk("mid_state", 32'(state), 0);

        timeline(6);

        do_reset();
        for (int c = 1; c <= 8; c++) begin
            locked = (c - 1 == 2) ? 2'b01 : 2'b11;
            tick();
            if (c == 6) chk("gl_wait6", 32'(state), 1);
            if (c == 7) chk("gl_hold7", 32'(state), 2);
        end
        locked = 2'b11;

        for (int i = 1; i <= 256; i++) begin
            wait_state(2, 40);
            locked = 2'b10;
            tick();
            locked = 2'b11;
            if (i == 1) chk("sat_1", 32'(fault), 1);
            if (i == 254) chk("sat_254", 32'(fault), 254);
            if (i == 256) chk("sat_256", 32'(fault), 255);
        end

        for (int i = 0; i < 6000; i++) begin
            dropr = ((i / 500) % 2 == 1) ? 200 : 30;
            rst = ($urandom_range(0, 299) == 0);
            locked = ($urandom_range(0, dropr) == 0)
                   ? 2'($urandom_range(0, 2)) : 2'b11;
            swrst = ($urandom_range(0, 24) == 0);
            tick();
        end
        rst = 1'b0;
        swrst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
